// File: rtl/rv_pkg.sv
// Shared RV core definitions: default datapath widths, the canonical NOP
// encoding, and the ALU/branch operation codes used by the execute stage.
package rv_pkg;

    // Default PC and instruction widths for the core.
    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;

    // addi x0, x0, 0 -- the canonical RISC-V NOP.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // ALU operation select used by the execute stage.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Branch comparison select used by the execute stage.
    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } br_op_e;

    // Pointer width needed to index DEPTH entries (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fq_ptr.sv
// Modulo-DEPTH pointer with increment and clear. Wraps from DEPTH-1 to 0
// for any DEPTH, so non-power-of-two queues work without special casing.
module fq_ptr
    import rv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Pointer register: reset and clear win over increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == LAST) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch stage and IF/ID.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high and flush is low. push_ready is a flop (not-full), so it never
// depends combinationally on pop_ready; a push offered while full is dropped
// even if a pop happens on the same edge, and it sets the sticky overflow
// flag. pop_valid is not-empty; a pushed entry shows at the head one cycle
// later (no bypass). flush (EX branch taken) discards everything; reset has
// priority over flush. An IF/ID hazard stall appears here as pop_ready low.
module fetch_queue
    import rv_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int ILEN  = ILEN_DEF,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [XLEN-1:0] push_pc,
    input  logic [ILEN-1:0] push_ir,
    output logic            pop_valid,
    input  logic            pop_ready,
    output logic [XLEN-1:0] pop_pc,
    output logic [ILEN-1:0] pop_ir,
    input  logic            flush,
    output logic [CW-1:0]   count,
    output logic            overflow
);

    localparam int            PW      = ptr_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [ILEN-1:0] NOP_IR = ILEN'(NOP_INSN);

    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [ILEN-1:0] ir_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          push_ready_q;
    logic          overflow_q;

    logic do_push;
    logic do_pop;
    logic drop_push;

    assign pop_valid  = (count_q != '0);
    assign push_ready = push_ready_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

    // Qualify transfers; flush suppresses every same-edge push and pop.
    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        drop_push = 1'b0;
        if (!flush) begin
            do_push   = push_valid && push_ready_q;
            do_pop    = pop_valid && pop_ready;
            drop_push = push_valid && !push_ready_q;
        end
    end

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count_q + CW'(1);
                2'b01:   count_nxt = count_q - CW'(1);
                default: count_nxt = count_q;
            endcase
        end
    end

    // Occupancy, registered not-full and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q      <= '0;
            push_ready_q <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            count_q      <= count_nxt;
            push_ready_q <= (count_nxt != FULL_CNT);
            if (drop_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Entry storage is not reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr] <= push_pc;
            ir_mem[wr_ptr] <= push_ir;
        end
    end

    // Head view: storage when non-empty, zero PC and NOP otherwise.
    always_comb begin
        pop_pc = '0;
        pop_ir = NOP_IR;
        if (pop_valid) begin
            pop_pc = pc_mem[rd_ptr];
            pop_ir = ir_mem[rd_ptr];
        end
    end

    fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (do_pop),
        .ptr (rd_ptr)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (do_push),
        .ptr (wr_ptr)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a DEPTH=4 instance for fill/drain, full,
// flush, reset and streaming, and a DEPTH=3 instance for non-power-of-two wrap.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;

    // DEPTH=4 instance signals
    logic        push_valid, push_ready, pop_valid, pop_ready, flush, overflow;
    logic [63:0] push_pc, pop_pc;
    logic [31:0] push_ir, pop_ir;
    logic [2:0]  count;

    // DEPTH=3 instance signals
    logic        push_valid3, push_ready3, pop_valid3, pop_ready3, flush3, overflow3;
    logic [63:0] push_pc3, pop_pc3;
    logic [31:0] push_ir3, pop_ir3;
    logic [1:0]  count3;

    logic [63:0] exp_q[$];
    logic [63:0] exp3_q[$];

    int checks = 0;
    int errors = 0;

    fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pc(push_pc), .push_ir(push_ir),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_pc(pop_pc), .pop_ir(pop_ir),
        .flush(flush), .count(count), .overflow(overflow)
    );

    fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .push_valid(push_valid3), .push_ready(push_ready3),
        .push_pc(push_pc3), .push_ir(push_ir3),
        .pop_valid(pop_valid3), .pop_ready(pop_ready3),
        .pop_pc(pop_pc3), .pop_ir(pop_ir3),
        .flush(flush3), .count(count3), .overflow(overflow3)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ir_of(input logic [63:0] pc);
        return 32'hC0DE_0000 ^ pc[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // DEPTH=4 driver with scoreboard update. Before the edge, a pop that the
    // model expects to happen is checked against the head of exp_q.
    task automatic drive4(input logic pv, input logic [63:0] pc,
                          input logic pr, input logic fl, input string tag);
        int sz;
        push_valid = pv;
        push_pc    = pc;
        push_ir    = ir_of(pc);
        pop_ready  = pr;
        flush      = fl;
        sz = exp_q.size();
        if (pr && !fl && sz > 0) begin
            chk({tag, "_pop_pc"}, pop_pc, exp_q[0]);
            chk({tag, "_pop_ir"}, {32'h0, pop_ir}, {32'h0, ir_of(exp_q[0])});
        end
        step();
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pr && sz > 0) void'(exp_q.pop_front());
            if (pv && sz < 4) exp_q.push_back(pc);
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    // DEPTH=3 driver with scoreboard update.
    task automatic drive3(input logic pv, input logic [63:0] pc,
                          input logic pr, input string tag);
        int sz;
        push_valid3 = pv;
        push_pc3    = pc;
        push_ir3    = ir_of(pc);
        pop_ready3  = pr;
        sz = exp3_q.size();
        if (pr && sz > 0) begin
            chk({tag, "_pop_pc"}, pop_pc3, exp3_q[0]);
            chk({tag, "_pop_ir"}, {32'h0, pop_ir3}, {32'h0, ir_of(exp3_q[0])});
        end
        step();
        if (pr && sz > 0) void'(exp3_q.pop_front());
        if (pv && sz < 3) exp3_q.push_back(pc);
        chk({tag, "_count"}, {62'h0, count3}, exp3_q.size());
        chk({tag, "_count_le3"}, {63'h0, (count3 <= 2'd3) && (count3 != 2'd0 || exp3_q.size() == 0)}, 64'h1);
        push_valid3 = 1'b0;
        pop_ready3  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        push_valid = 0; push_pc = '0; push_ir = '0; pop_ready = 0; flush = 0;
        push_valid3 = 0; push_pc3 = '0; push_ir3 = '0; pop_ready3 = 0; flush3 = 0;
        step();
        step();
        rst = 1'b1;

        // Reset state
        chk("rst_count", {61'h0, count}, 64'd0);
        chk("rst_pop_valid", {63'h0, pop_valid}, 64'd0);
        chk("rst_push_ready", {63'h0, push_ready}, 64'd1);
        chk("rst_overflow", {63'h0, overflow}, 64'd0);
        chk("rst_pop_pc", pop_pc, 64'd0);
        chk("rst_pop_ir", {32'h0, pop_ir}, {32'h0, NOP});

        // Fill then drain; first push is visible one cycle later
        drive4(1, 64'h0, 0, 0, "fill0");
        chk("fill_latency_valid", {63'h0, pop_valid}, 64'd1);
        chk("fill_latency_pc", pop_pc, 64'h0);
        drive4(1, 64'h4, 0, 0, "fill1");
        drive4(1, 64'h8, 0, 0, "fill2");
        drive4(1, 64'hC, 0, 0, "fill3");
        chk("full_count", {61'h0, count}, 64'd4);
        chk("full_push_ready", {63'h0, push_ready}, 64'd0);
        for (int i = 0; i < 4; i++) drive4(0, 64'h0, 1, 0, "drain");
        chk("drain_count", {61'h0, count}, 64'd0);
        chk("drain_pop_valid", {63'h0, pop_valid}, 64'd0);
        chk("drain_pop_ir_nop", {32'h0, pop_ir}, {32'h0, NOP});
        drive4(0, 64'h0, 1, 0, "pop_empty");
        chk("pop_empty_count", {61'h0, count}, 64'd0);
        chk("pop_empty_overflow", {63'h0, overflow}, 64'd0);

        // Full with simultaneous push and pop: push rejected, overflow set
        for (int i = 0; i < 4; i++) drive4(1, 64'h40 + 64'(4 * i), 0, 0, "refill");
        chk("refill_count", {61'h0, count}, 64'd4);
        drive4(1, 64'h10, 1, 0, "full_pushpop");
        chk("full_pushpop_overflow", {63'h0, overflow}, 64'd1);
        chk("full_pushpop_count", {61'h0, count}, 64'd3);
        chk("full_pushpop_ready", {63'h0, push_ready}, 64'd1);
        for (int i = 0; i < 3; i++) drive4(0, 64'h0, 1, 0, "drain2");
        chk("drain2_count", {61'h0, count}, 64'd0);

        // Flush race: flush wins over same-edge push and pop
        drive4(1, 64'h50, 0, 0, "pre_flush0");
        drive4(1, 64'h54, 0, 0, "pre_flush1");
        chk("pre_flush_count", {61'h0, count}, 64'd2);
        drive4(1, 64'h20, 1, 1, "flush");
        chk("flush_count", {61'h0, count}, 64'd0);
        chk("flush_pop_valid", {63'h0, pop_valid}, 64'd0);
        chk("flush_pop_ir", {32'h0, pop_ir}, {32'h0, NOP});
        chk("flush_pop_pc", pop_pc, 64'd0);
        chk("flush_keeps_overflow", {63'h0, overflow}, 64'd1);
        chk("flush_push_ready", {63'h0, push_ready}, 64'd1);
        drive4(1, 64'h60, 0, 0, "post_flush");
        chk("post_flush_head", pop_pc, 64'h60);
        drive4(0, 64'h0, 1, 0, "post_flush_pop");
        chk("post_flush_empty", {63'h0, pop_valid}, 64'd0);

        // Reset mid-stream with overflow set
        for (int i = 0; i < 3; i++) drive4(1, 64'h80 + 64'(4 * i), 0, 0, "pre_rst");
        chk("pre_rst_count", {61'h0, count}, 64'd3);
        chk("pre_rst_overflow", {63'h0, overflow}, 64'd1);
        rst = 1'b0;
        push_valid = 1'b1; push_pc = 64'h99; push_ir = ir_of(64'h99);
        pop_ready = 1'b1; flush = 1'b1;
        step();
        rst = 1'b1;
        push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
        exp_q.delete();
        exp3_q.delete();
        chk("midrst_count", {61'h0, count}, 64'd0);
        chk("midrst_overflow", {63'h0, overflow}, 64'd0);
        chk("midrst_push_ready", {63'h0, push_ready}, 64'd1);
        chk("midrst_pop_valid", {63'h0, pop_valid}, 64'd0);
        drive4(1, 64'h70, 0, 0, "post_rst");
        chk("post_rst_head", pop_pc, 64'h70);
        chk("post_rst_count", {61'h0, count}, 64'd1);

        // Steady streaming from count=1: no bubbles, count stays 1
        for (int i = 0; i < 20; i++) begin
            chk("stream_valid", {63'h0, pop_valid}, 64'd1);
            drive4(1, 64'h100 + 64'(4 * i), 1, 0, "stream");
            chk("stream_count", {61'h0, count}, 64'd1);
        end
        chk("stream_head", pop_pc, 64'h100 + 64'(4 * 19));
        chk("stream_overflow", {63'h0, overflow}, 64'd0);

        // DEPTH=3 wrap: 10 pushes and 10 pops interleaved
        chk("d3_rst_count", {62'h0, count3}, 64'd0);
        chk("d3_rst_pop_ir", {32'h0, pop_ir3}, {32'h0, NOP});
        for (int i = 0; i < 3; i++) drive3(1, 64'h200 + 64'(4 * i), 0, "d3_fill");
        chk("d3_full_ready", {63'h0, push_ready3}, 64'd0);
        drive3(0, 64'h0, 1, "d3_pop");
        chk("d3_ready_after_pop", {63'h0, push_ready3}, 64'd1);
        for (int i = 3; i < 9; i++) drive3(1, 64'h200 + 64'(4 * i), 1, "d3_pushpop");
        drive3(1, 64'h200 + 64'(4 * 9), 0, "d3_last_push");
        for (int i = 0; i < 3; i++) drive3(0, 64'h0, 1, "d3_drain");
        chk("d3_empty", {63'h0, pop_valid3}, 64'd0);
        chk("d3_overflow", {63'h0, overflow3}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
